axi_lite_reg_sweep_master: RTL and testbench
============================================

Name: axi_lite_reg_sweep_master

Overview:
Synthesizable AXI4-Lite master that sweeps a parametrised window of slave registers.
- Writes a generated data pattern to each register, reads it back, compares it, and counts errors. This is the in-fabric, self-checking successor to the BFM write/readback flow.
- Generalises data/address width, register count, stride and ordering mode.
- Adds response checking and a per-transaction watchdog.
- Sits between a control/status register block or a JTAG-driven control bus and any AXI4-Lite register-space slave.

Parameters:
C_M_AXI_ADDR_WIDTH, 32, address bus width.
C_M_AXI_DATA_WIDTH, 32, data bus width (32 or 64).
C_NUM_REGS, 4, registers swept per run (1..1024).
C_BASE_ADDR, 32'h0, byte address of the first register.
C_ADDR_STRIDE, C_M_AXI_DATA_WIDTH/8, byte increment between registers.
C_MODE, 0, ordering: 0 = interleaved (write i, read i), 1 = phased (write all, then read all).
C_TIMEOUT, 1023, maximum wait cycles per channel handshake before abort.

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
start  in  1  level-sampled; launches a run when idle
seed  in  DW  data for register 0; sampled when start is accepted
step  in  DW  data increment per register; sampled with seed
busy  out  1  run in progress
done  out  1  run finished; held until next accepted start
pass  out  1  valid while done; 1 iff err_count==0 and no timeout
timeout  out  1  run aborted by watchdog; valid while done
err_count  out  clog2(C_NUM_REGS+1)  mismatches plus non-OKAY responses, saturating
first_err_addr  out  AW  address of first error; 0 if none
M_AXI_AWADDR/AWPROT/AWVALID/AWREADY  out/out/out/in  AW/3/1/1  write address channel; AWPROT=0
M_AXI_WDATA/WSTRB/WVALID/WREADY  out/out/out/in  DW/DW/8/1/1  write data channel; WSTRB all ones
M_AXI_BRESP/BVALID/BREADY  in/in/out  2/1/1  write response channel
M_AXI_ARADDR/ARPROT/ARVALID/ARREADY  out/out/out/in  AW/3/1/1  read address channel; ARPROT=0
M_AXI_RDATA/RRESP/RVALID/RREADY  in/in/in/out  DW/2/1/1  read data channel

Behaviour:
- Reset (async assert, sync release): all outputs 0; FSM is IDLE.
  - Reset mid-run drops every VALID/READY immediately. No transaction resumes after reset.
- Data and address generation:
  - data_i = seed + i*step, modulo 2^DW.
  - addr_i = C_BASE_ADDR + i*C_ADDR_STRIDE, modulo 2^AW; wraps silently.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, NEXT, FINISH.
- IDLE:
  - When start=1, latch seed/step, set i=0, clear done/pass/timeout/err_count/first_err_addr, and assert busy.
  - AWVALID and WVALID rise on the next cycle.
- WR_REQ:
  - AWVALID and WVALID are asserted together.
  - Each drops independently the cycle after its own handshake.
  - Move to WR_RESP once both handshakes are complete; same-cycle completion is allowed.
  - ADDR/DATA stay stable while VALID is high.
- WR_RESP:
  - BREADY=1 only in this state.
  - On BVALID, BRESP!=OKAY counts one error.
  - Next state: mode 0 → RD_REQ; mode 1 → NEXT.
- RD_REQ: ARVALID held until ARREADY, then RD_RESP.
- RD_RESP:
  - RREADY=1 only in this state.
  - On RVALID, RRESP!=OKAY counts one error.
  - RDATA!=data_i counts one error.
  - Both errors in the same beat count as 2, saturating.
- NEXT:
  - Mode 0: i++, go to WR_REQ; go to FINISH after i=C_NUM_REGS-1.
  - Mode 1: write phase loops over all i through WR_REQ; then i is reset to 0 and the read phase loops over all i through RD_REQ.
- first_err_addr captures addr_i on the first error only.
- Watchdog:
  - Counter resets on every state change and counts while waiting for READY/VALID.
  - At C_TIMEOUT it sets timeout=1, drops all VALID/READY and goes to FINISH.
  - A late response after abort is ignored; BREADY/RREADY stay 0.
- FINISH: busy=0, done=1, pass computed; return to IDLE. start held high re-launches the run one cycle later.
- start while busy is ignored.
- No outstanding transactions: at most one write or one read in flight.

Decomposition:
- Package axi_sweep_pkg holds:
  - state enum;
  - RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR, RESP_DECERR;
  - MODE_INTERLEAVED, MODE_PHASED;
  - the clog2 function.
- One sub-module, axi_sweep_watchdog: counter with clear, enable and expire output, parametrised by C_TIMEOUT.
- Everything else stays in the top module.

Test Plan:
1. Mode 0, 4 regs, seed=32'h0101FFFF, step=32'h11110001, slave register-file model with random READY delays 0-5 → writes 0101FFFF, 1213_0000, 2324_0001, 3435_0002 to 0x0, 0x4, 0x8, 0xC; done=1, pass=1, err_count=0.
2. Mode 1, same stimulus → all 4 AW handshakes precede any AR handshake; pass=1.
3. Slave corrupts reg 2 readback (XOR 1) → err_count=1, first_err_addr=0x8, pass=0.
4. Slave returns BRESP=SLVERR on reg 1 and mismatched RDATA on reg 1 → err_count=2, first_err_addr=0x4.
5. Slave never asserts ARREADY, C_TIMEOUT=15 → ARVALID high exactly 15 cycles, then drops; timeout=1, pass=0, done=1.
6. ARESETN pulsed low while in WR_REQ → all VALIDs are 0 in the same cycle; busy=0. A new start then completes normally with pass=1.

Source files
------------

// File: rtl/axi_sweep_pkg.sv
// Shared types and constants for the AXI4-Lite register sweep master.
package axi_sweep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_NEXT,
        ST_FINISH
    } sweep_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int MODE_INTERLEAVED = 0;
    localparam int MODE_PHASED      = 1;

    function automatic int clog2(input int value);
        int result = 0;
        int remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/axi_sweep_watchdog.sv
// Per-handshake wait counter; expire fires on the C_TIMEOUT-th consecutive enabled cycle.
module axi_sweep_watchdog
    import axi_sweep_pkg::*;
#(
    parameter int C_TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int TW = clog2(C_TIMEOUT + 1);
    localparam logic [TW-1:0] LAST_CNT = TW'(C_TIMEOUT - 1);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr || !en) begin
            cnt_d = '0;
        end else if (cnt_q != LAST_CNT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = en && (cnt_q == LAST_CNT);

endmodule

// File: rtl/axi_lite_reg_sweep_master.sv
// AXI4-Lite master: writes seed + i*step to a register window, reads back, counts errors.
module axi_lite_reg_sweep_master
    import axi_sweep_pkg::*;
#(
    parameter int                            C_M_AXI_ADDR_WIDTH = 32,
    parameter int                            C_M_AXI_DATA_WIDTH = 32,
    parameter int                            C_NUM_REGS         = 4,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = '0,
    parameter int                            C_ADDR_STRIDE      = C_M_AXI_DATA_WIDTH / 8,
    parameter int                            C_MODE             = MODE_INTERLEAVED,
    parameter int                            C_TIMEOUT          = 1023
) (
    input  logic                                 ACLK,
    input  logic                                 ARESETN,
    input  logic                                 start,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]        seed,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]        step,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 pass,
    output logic                                 timeout,
    output logic [clog2(C_NUM_REGS+1)-1:0]       err_count,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]        first_err_addr,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]        M_AXI_AWADDR,
    output logic [2:0]                           M_AXI_AWPROT,
    output logic                                 M_AXI_AWVALID,
    input  logic                                 M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]        M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]      M_AXI_WSTRB,
    output logic                                 M_AXI_WVALID,
    input  logic                                 M_AXI_WREADY,
    input  logic [1:0]                           M_AXI_BRESP,
    input  logic                                 M_AXI_BVALID,
    output logic                                 M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]        M_AXI_ARADDR,
    output logic [2:0]                           M_AXI_ARPROT,
    output logic                                 M_AXI_ARVALID,
    input  logic                                 M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]        M_AXI_RDATA,
    input  logic [1:0]                           M_AXI_RRESP,
    input  logic                                 M_AXI_RVALID,
    output logic                                 M_AXI_RREADY
);

    // state      | meaning
    // IDLE       | waiting for start
    // WR_REQ     | AW and W valid until each handshakes
    // WR_RESP    | BREADY high, waiting for BVALID
    // RD_REQ     | ARVALID high until ARREADY
    // RD_RESP    | RREADY high, waiting for RVALID
    // NEXT       | advance register index / switch phase
    // FINISH     | publish done/pass, back to IDLE

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int CW = clog2(C_NUM_REGS + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(C_NUM_REGS - 1);
    localparam logic [AW-1:0] STRIDE   = AW'(C_ADDR_STRIDE);
    localparam bit            PHASED   = (C_MODE == MODE_PHASED);

    sweep_state_e  state_q, state_d;
    logic [CW-1:0] idx_q, idx_d;
    logic          phase_q, phase_d;
    logic [DW-1:0] seed_q, seed_d;
    logic [DW-1:0] step_q, step_d;
    logic [DW-1:0] data_q, data_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] first_err_addr_q, first_err_addr_d;
    logic [CW-1:0] err_q, err_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;
    logic          awvalid_q, awvalid_d;
    logic          wvalid_q, wvalid_d;
    logic          arvalid_q, arvalid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic          timeout_q, timeout_d;

    logic          aw_hs, w_hs;
    logic          progress, wait_en, expire, abort;
    logic          err_clr;
    logic [1:0]    err_inc;
    logic [CW:0]   err_sum;

    axi_sweep_watchdog #(
        .C_TIMEOUT (C_TIMEOUT)
    ) u_watchdog (
        .clk    (ACLK),
        .rst_n  (ARESETN),
        .clr    (progress),
        .en     (wait_en),
        .expire (expire)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        phase_d   = phase_q;
        seed_d    = seed_q;
        step_d    = step_q;
        data_d    = data_q;
        addr_d    = addr_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        err_inc   = 2'd0;
        err_clr   = 1'b0;
        progress  = 1'b1;
        wait_en   = 1'b0;
        abort     = 1'b0;
        aw_hs     = awvalid_q && M_AXI_AWREADY;
        w_hs      = wvalid_q && M_AXI_WREADY;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    seed_d    = seed;
                    step_d    = step;
                    data_d    = seed;
                    addr_d    = C_BASE_ADDR;
                    idx_d     = '0;
                    phase_d   = 1'b0;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
                    err_clr   = 1'b1;
                    busy_d    = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = ST_WR_REQ;
                end
            end
            ST_WR_REQ: begin
                wait_en = 1'b1;
                if (aw_hs) begin
                    aw_done_d = 1'b1;
                    awvalid_d = 1'b0;
                end
                if (w_hs) begin
                    w_done_d = 1'b1;
                    wvalid_d = 1'b0;
                end
                progress = (aw_done_q || aw_hs) && (w_done_q || w_hs);
                if (progress) begin
                    state_d = ST_WR_RESP;
                end else if (expire) begin
                    abort = 1'b1;
                end
            end
            ST_WR_RESP: begin
                wait_en  = 1'b1;
                progress = M_AXI_BVALID;
                if (M_AXI_BVALID) begin
                    err_inc = {1'b0, M_AXI_BRESP != RESP_OKAY};
                    if (PHASED) begin
                        state_d = ST_NEXT;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_REQ;
                    end
                end else if (expire) begin
                    abort = 1'b1;
                end
            end
            ST_RD_REQ: begin
                wait_en  = 1'b1;
                progress = arvalid_q && M_AXI_ARREADY;
                if (progress) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_RD_RESP;
                end else if (expire) begin
                    abort = 1'b1;
                end
            end
            ST_RD_RESP: begin
                wait_en  = 1'b1;
                progress = M_AXI_RVALID;
                if (M_AXI_RVALID) begin
                    err_inc = {1'b0, M_AXI_RRESP != RESP_OKAY}
                            + {1'b0, M_AXI_RDATA != data_q};
                    state_d = ST_NEXT;
                end else if (expire) begin
                    abort = 1'b1;
                end
            end
            ST_NEXT: begin
                if (idx_q == LAST_IDX && (!PHASED || phase_q)) begin
                    state_d = ST_FINISH;
                end else if (idx_q == LAST_IDX) begin
                    // phased mode: write phase complete, restart the window for readback
                    phase_d   = 1'b1;
                    idx_d     = '0;
                    data_d    = seed_q;
                    addr_d    = C_BASE_ADDR;
                    arvalid_d = 1'b1;
                    state_d   = ST_RD_REQ;
                end else begin
                    idx_d  = idx_q + 1'b1;
                    data_d = data_q + step_q;
                    addr_d = addr_q + STRIDE;
                    if (PHASED && phase_q) begin
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_REQ;
                    end else begin
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WR_REQ;
                    end
                end
            end
            ST_FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (err_q == '0) && !timeout_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            arvalid_d = 1'b0;
            timeout_d = 1'b1;
            state_d   = ST_FINISH;
        end
    end

    // err_q stays nonzero once set, so err_q == 0 marks "no error seen yet"
    always_comb begin
        err_sum          = {1'b0, err_q} + (CW+1)'(err_inc);
        err_d            = err_sum[CW] ? '1 : err_sum[CW-1:0];
        first_err_addr_d = first_err_addr_q;
        if (err_clr) begin
            err_d            = '0;
            first_err_addr_d = '0;
        end else if (err_inc != 2'd0 && err_q == '0) begin
            first_err_addr_d = addr_q;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q          <= ST_IDLE;
            idx_q            <= '0;
            phase_q          <= 1'b0;
            seed_q           <= '0;
            step_q           <= '0;
            data_q           <= '0;
            addr_q           <= '0;
            first_err_addr_q <= '0;
            err_q            <= '0;
            aw_done_q        <= 1'b0;
            w_done_q         <= 1'b0;
            awvalid_q        <= 1'b0;
            wvalid_q         <= 1'b0;
            arvalid_q        <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            timeout_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            phase_q          <= phase_d;
            seed_q           <= seed_d;
            step_q           <= step_d;
            data_q           <= data_d;
            addr_q           <= addr_d;
            first_err_addr_q <= first_err_addr_d;
            err_q            <= err_d;
            aw_done_q        <= aw_done_d;
            w_done_q         <= w_done_d;
            awvalid_q        <= awvalid_d;
            wvalid_q         <= wvalid_d;
            arvalid_q        <= arvalid_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
            timeout_q        <= timeout_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign timeout        = timeout_q;
    assign err_count      = err_q;
    assign first_err_addr = first_err_addr_q;

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = data_q;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = (state_q == ST_WR_RESP);
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = (state_q == ST_RD_RESP);

endmodule

// File: tb/tb_axi_lite_reg_sweep_master.sv
// Bench: two sweep masters (interleaved, phased) sharing one register-file slave model.
module tb_axi_lite_reg_sweep_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 4;
    localparam int TO = 15;
    localparam int CW = 3;

    logic ACLK = 1'b0;
    logic ARESETN = 1'b0;
    always #5 ACLK = ~ACLK;

    logic          start0 = 1'b0, start1 = 1'b0;
    logic [DW-1:0] seed = '0, step = '0;
    logic          sel = 1'b0;

    logic          busy0, done0, pass0, timeout0, busy1, done1, pass1, timeout1;
    logic [CW-1:0] err0, err1;
    logic [AW-1:0] fea0, fea1;
    logic [AW-1:0] awaddr0, araddr0, awaddr1, araddr1;
    logic [2:0]    awprot0, arprot0, awprot1, arprot1;
    logic [DW-1:0] wdata0, wdata1;
    logic [DW/8-1:0] wstrb0, wstrb1;
    logic          awvalid0, wvalid0, bready0, arvalid0, rready0;
    logic          awvalid1, wvalid1, bready1, arvalid1, rready1;

    logic          awready, wready, bvalid, arready, rvalid;
    logic [1:0]    bresp, rresp;
    logic [DW-1:0] rdata;

    logic          s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
    logic [AW-1:0] s_awaddr, s_araddr;
    logic [DW-1:0] s_wdata;
    assign s_awvalid = sel ? awvalid1 : awvalid0;
    assign s_wvalid  = sel ? wvalid1  : wvalid0;
    assign s_bready  = sel ? bready1  : bready0;
    assign s_arvalid = sel ? arvalid1 : arvalid0;
    assign s_rready  = sel ? rready1  : rready0;
    assign s_awaddr  = sel ? awaddr1  : awaddr0;
    assign s_araddr  = sel ? araddr1  : araddr0;
    assign s_wdata   = sel ? wdata1   : wdata0;

    axi_lite_reg_sweep_master #(
        .C_NUM_REGS(NR), .C_MODE(0), .C_TIMEOUT(TO)
    ) dut0 (
        .ACLK(ACLK), .ARESETN(ARESETN), .start(start0), .seed(seed), .step(step),
        .busy(busy0), .done(done0), .pass(pass0), .timeout(timeout0),
        .err_count(err0), .first_err_addr(fea0),
        .M_AXI_AWADDR(awaddr0), .M_AXI_AWPROT(awprot0), .M_AXI_AWVALID(awvalid0),
        .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata0), .M_AXI_WSTRB(wstrb0),
        .M_AXI_WVALID(wvalid0), .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
        .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready0), .M_AXI_ARADDR(araddr0),
        .M_AXI_ARPROT(arprot0), .M_AXI_ARVALID(arvalid0), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
        .M_AXI_RREADY(rready0)
    );

    axi_lite_reg_sweep_master #(
        .C_NUM_REGS(NR), .C_MODE(1), .C_TIMEOUT(TO)
    ) dut1 (
        .ACLK(ACLK), .ARESETN(ARESETN), .start(start1), .seed(seed), .step(step),
        .busy(busy1), .done(done1), .pass(pass1), .timeout(timeout1),
        .err_count(err1), .first_err_addr(fea1),
        .M_AXI_AWADDR(awaddr1), .M_AXI_AWPROT(awprot1), .M_AXI_AWVALID(awvalid1),
        .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata1), .M_AXI_WSTRB(wstrb1),
        .M_AXI_WVALID(wvalid1), .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
        .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready1), .M_AXI_ARADDR(araddr1),
        .M_AXI_ARPROT(arprot1), .M_AXI_ARVALID(arvalid1), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
        .M_AXI_RREADY(rready1)
    );

    // slave knobs, written only by the stimulus block
    int corrupt_idx = -1;
    int slverr_idx = -1;
    bit never_arready = 1'b0;

    // slave state, written only by the slave process (drives at negedge)
    logic [DW-1:0] mem [16];
    logic [AW-1:0] aw_addr, ar_addr;
    logic [DW-1:0] w_data;
    bit  aw_have, w_have, b_pend, r_pend, ar_early;
    int  aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    int  wr_cnt, aw_hs_cnt, ar_hs_cnt, arv_cycles;
    logic [AW-1:0] wr_addr_log [8];
    logic [DW-1:0] wr_data_log [8];

    always @(negedge ACLK) begin
        if (!ARESETN) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            bresp = 2'b00; rresp = 2'b00; rdata = '0;
            aw_have = 0; w_have = 0; b_pend = 0; r_pend = 0; ar_early = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            wr_cnt = 0; aw_hs_cnt = 0; ar_hs_cnt = 0; arv_cycles = 0;
        end else begin
            if (s_arvalid) arv_cycles++;
            if (awready) begin
                awready = 0; aw_have = 1; aw_hs_cnt++; aw_cnt = $urandom_range(0, 5);
            end else if (s_awvalid && !aw_have) begin
                if (aw_cnt == 0) begin awready = 1; aw_addr = s_awaddr; end
                else aw_cnt--;
            end
            if (wready) begin
                wready = 0; w_have = 1; w_cnt = $urandom_range(0, 5);
            end else if (s_wvalid && !w_have) begin
                if (w_cnt == 0) begin wready = 1; w_data = s_wdata; end
                else w_cnt--;
            end
            if (aw_have && w_have) begin
                mem[aw_addr[5:2]] = w_data;
                if (wr_cnt < 8) begin
                    wr_addr_log[wr_cnt] = aw_addr;
                    wr_data_log[wr_cnt] = w_data;
                end
                wr_cnt++;
                bresp = (int'(aw_addr[5:2]) == slverr_idx) ? 2'b10 : 2'b00;
                aw_have = 0; w_have = 0; b_pend = 1;
            end
            if (bvalid) bvalid = 0;
            else if (b_pend && s_bready) begin
                if (b_cnt == 0) begin bvalid = 1; b_pend = 0; b_cnt = $urandom_range(0, 5); end
                else b_cnt--;
            end
            if (arready) begin
                arready = 0; ar_hs_cnt++; r_pend = 1; ar_cnt = $urandom_range(0, 5);
                if (aw_hs_cnt < NR) ar_early = 1;
                rdata = mem[ar_addr[5:2]] ^ ((int'(ar_addr[5:2]) == corrupt_idx) ? 32'd1 : 32'd0);
                rresp = 2'b00;
            end else if (s_arvalid && !never_arready) begin
                if (ar_cnt == 0) begin arready = 1; ar_addr = s_araddr; end
                else ar_cnt--;
            end
            if (rvalid) rvalid = 0;
            else if (r_pend && s_rready) begin
                if (r_cnt == 0) begin rvalid = 1; r_pend = 0; r_cnt = $urandom_range(0, 5); end
                else r_cnt--;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic do_reset();
        ARESETN = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        repeat (3) @(negedge ACLK);
        #2 ARESETN = 1'b1;
        @(negedge ACLK);
        #1;
    endtask

    task automatic start_run(input bit which);
        @(negedge ACLK);
        #1;
        if (which) start1 = 1'b1; else start0 = 1'b1;
        @(negedge ACLK);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input bit which, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge ACLK);
            #1;
            if ((which ? done1 : done0) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [10:0] st0, st1;
        do_reset();
        st0 = {busy0, done0, pass0, timeout0, err0, awvalid0, wvalid0, arvalid0, bready0, rready0};
        st1 = {busy1, done1, pass1, timeout1, err1, awvalid1, wvalid1, arvalid1, bready1, rready1};
        checks++;
        if (st0 !== 11'd0) begin errors++; $display("FAIL reset_ctrl0 got %b want 0", st0); end
        checks++;
        if (st1 !== 11'd0) begin errors++; $display("FAIL reset_ctrl1 got %b want 0", st1); end
        checks++;
        if ({fea0, fea1} !== 64'd0) begin errors++; $display("FAIL reset_fea got %h %h want 0", fea0, fea1); end
        checks++;
        if ({awprot0, arprot0, awprot1, arprot1, wstrb0, wstrb1} !== {12'd0, 8'hFF}) begin
            errors++; $display("FAIL reset_prot_strb got %h want 0ff", {awprot0, arprot0, awprot1, arprot1, wstrb0, wstrb1});
        end
    endtask

    task automatic test_interleaved();
        bit ok;
        logic [DW-1:0] exp_d [4];
        exp_d[0] = 32'h0101FFFF; exp_d[1] = 32'h12130000;
        exp_d[2] = 32'h23240001; exp_d[3] = 32'h34350002;
        sel = 1'b0; corrupt_idx = -1; slverr_idx = -1; never_arready = 1'b0;
        do_reset();
        seed = 32'h0101FFFF; step = 32'h11110001;
        start_run(1'b0);
        checks++;
        if (busy0 !== 1'b1 || awvalid0 !== 1'b1 || wvalid0 !== 1'b1) begin
            errors++; $display("FAIL t1_launch busy/aw/w got %b%b%b want 111", busy0, awvalid0, wvalid0);
        end
        wait_done(1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL t1_done_wait got no done want done within bound"); end
        checks++;
        if ({done0, pass0, busy0, timeout0, err0} !== {4'b1100, 3'd0}) begin
            errors++; $display("FAIL t1_status got d%b p%b b%b t%b e%0d want d1 p1 b0 t0 e0", done0, pass0, busy0, timeout0, err0);
        end
        checks++;
        if (wr_cnt !== NR) begin errors++; $display("FAIL t1_write_count got %0d want %0d", wr_cnt, NR); end
        for (int i = 0; i < NR; i++) begin
            checks++;
            if (wr_addr_log[i] !== AW'(4 * i) || wr_data_log[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL t1_write%0d got %h:%h want %h:%h", i, wr_addr_log[i], wr_data_log[i], AW'(4 * i), exp_d[i]);
            end
        end
    endtask

    task automatic test_phased();
        bit ok;
        sel = 1'b1; corrupt_idx = -1; slverr_idx = -1; never_arready = 1'b0;
        do_reset();
        seed = 32'h0101FFFF; step = 32'h11110001;
        start_run(1'b1);
        wait_done(1'b1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL t2_done_wait got no done want done within bound"); end
        checks++;
        if (ar_early !== 1'b0 || aw_hs_cnt !== NR || ar_hs_cnt !== NR) begin
            errors++; $display("FAIL t2_order got early=%b aw=%0d ar=%0d want early=0 aw=4 ar=4", ar_early, aw_hs_cnt, ar_hs_cnt);
        end
        checks++;
        if ({pass1, timeout1, err1, fea1} !== {2'b10, 3'd0, 32'd0}) begin
            errors++; $display("FAIL t2_status got p%b t%b e%0d a%h want p1 t0 e0 a0", pass1, timeout1, err1, fea1);
        end
        sel = 1'b0;
    endtask

    task automatic test_corrupt_read();
        bit ok;
        sel = 1'b0; corrupt_idx = 2; slverr_idx = -1; never_arready = 1'b0;
        do_reset();
        seed = 32'hA5A50000; step = 32'h00000003;
        start_run(1'b0);
        wait_done(1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL t3_done_wait got no done want done within bound"); end
        checks++;
        if (err0 !== 3'd1 || fea0 !== 32'h8 || pass0 !== 1'b0) begin
            errors++; $display("FAIL t3_corrupt got e%0d a%h p%b want e1 a8 p0", err0, fea0, pass0);
        end
    endtask

    task automatic test_slverr_and_mismatch();
        bit ok;
        sel = 1'b0; corrupt_idx = 1; slverr_idx = 1; never_arready = 1'b0;
        do_reset();
        seed = 32'h00000010; step = 32'h00000100;
        start_run(1'b0);
        wait_done(1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL t4_done_wait got no done want done within bound"); end
        checks++;
        if (err0 !== 3'd2 || fea0 !== 32'h4 || pass0 !== 1'b0 || timeout0 !== 1'b0) begin
            errors++; $display("FAIL t4_slverr got e%0d a%h p%b t%b want e2 a4 p0 t0", err0, fea0, pass0, timeout0);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        sel = 1'b0; corrupt_idx = -1; slverr_idx = -1; never_arready = 1'b1;
        do_reset();
        seed = 32'h12345678; step = 32'h1;
        start_run(1'b0);
        wait_done(1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL t5_done_wait got no done want done within bound"); end
        checks++;
        if (arv_cycles !== TO) begin errors++; $display("FAIL t5_arvalid_cycles got %0d want %0d", arv_cycles, TO); end
        checks++;
        if ({done0, timeout0, pass0, busy0, arvalid0, rready0} !== 6'b110000) begin
            errors++; $display("FAIL t5_status got d%b t%b p%b b%b ar%b rr%b want d1 t1 p0 b0 ar0 rr0",
                                done0, timeout0, pass0, busy0, arvalid0, rready0);
        end
        never_arready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        sel = 1'b0; corrupt_idx = -1; slverr_idx = -1; never_arready = 1'b0;
        do_reset();
        seed = 32'hCAFE0000; step = 32'h00010001;
        start_run(1'b0);
        checks++;
        if (awvalid0 !== 1'b1) begin errors++; $display("FAIL t6_in_wr_req got awvalid %b want 1", awvalid0); end
        #1 ARESETN = 1'b0;
        #1;
        checks++;
        if ({awvalid0, wvalid0, arvalid0, bready0, rready0, busy0} !== 6'd0) begin
            errors++; $display("FAIL t6_reset_drop got %b want 000000", {awvalid0, wvalid0, arvalid0, bready0, rready0, busy0});
        end
        do_reset();
        start_run(1'b0);
        wait_done(1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL t6_done_wait got no done want done within bound"); end
        checks++;
        if (pass0 !== 1'b1 || err0 !== 3'd0 || wr_cnt !== NR) begin
            errors++; $display("FAIL t6_rerun got p%b e%0d w%0d want p1 e0 w4", pass0, err0, wr_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_interleaved();
        test_phased();
        test_corrupt_read();
        test_slverr_and_mismatch();
        test_timeout();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
